// File: rtl/encrypted_image_writer_pkg.sv
// Shared definitions for the encrypted-image writer: FSM states, submatrix geometry
// and the pixel-unpacking helper used wherever a 16-bit submatrix is split into pixels.
package encrypted_image_writer_pkg;

    localparam int unsigned PIX_W       = 4;
    localparam int unsigned SUB_DIM     = 2;
    localparam int unsigned PIX_PER_SUB = 4;
    localparam int unsigned SUB_DATA_W  = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_SUB,
        ST_WRITE,
        ST_ACK,
        ST_DONE
    } state_t;

    typedef logic [1:0] pix_idx_t;

    // Pixel k of a 2x2 tile in raster order: k0 is the top-left nibble [15:12].
    function automatic logic [PIX_W-1:0] sub_pixel(input logic [SUB_DATA_W-1:0] sub,
                                                   input pix_idx_t k);
        logic [PIX_W-1:0] pix;
        case (k)
            2'd0:    pix = sub[15:12];
            2'd1:    pix = sub[11:8];
            2'd2:    pix = sub[7:4];
            default: pix = sub[3:0];
        endcase
        return pix;
    endfunction

endpackage

// File: rtl/encrypted_image_writer_tile_position_counter.sv
// Tracks the top-left corner of the current 2x2 tile in raster tile order.
// rowBase is accumulated so the pixel address needs no multiplier.
module tile_position_counter
    import encrypted_image_writer_pkg::*;
#(
    parameter int IMG_W  = 160,
    parameter int IMG_H  = 120,
    parameter int ADDR_W = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              advance,
    input  logic              clear,
    output logic [ADDR_W-1:0] subX,
    output logic [ADDR_W-1:0] subY,
    output logic [ADDR_W-1:0] rowBase,
    output logic              last
);

    localparam logic [ADDR_W-1:0] X_LAST   = ADDR_W'(IMG_W - int'(SUB_DIM));
    localparam logic [ADDR_W-1:0] Y_LAST   = ADDR_W'(IMG_H - int'(SUB_DIM));
    localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(SUB_DIM);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(int'(SUB_DIM) * IMG_W);

    assign last = (subX == X_LAST) && (subY == Y_LAST);

    // clear wins over advance so the final tile's ack lands back at (0,0).
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            subX    <= '0;
            subY    <= '0;
            rowBase <= '0;
        end else if (advance) begin
            if (subX == X_LAST) begin
                subX    <= '0;
                subY    <= subY + STEP;
                rowBase <= rowBase + ROW_STEP;
            end else begin
                subX <= subX + STEP;
            end
        end
    end

endmodule

// File: rtl/encrypted_image_writer.sv
// Consumes encrypted submatrices, writes their four pixels into the frame memory
// in raster tile order and acknowledges each with a one-cycle processed pulse.
module encrypted_image_writer
    import encrypted_image_writer_pkg::*;
#(
    parameter int IMG_W  = 160,
    parameter int IMG_H  = 120,
    parameter int ADDR_W = 15
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  readyToBeProcessed,
    input  logic [SUB_DATA_W-1:0] imageGeneratorInput,
    output logic                  processed,
    output logic                  memWriteEn,
    output logic [ADDR_W-1:0]     memAddress,
    output logic [PIX_W-1:0]      memData,
    output logic                  busy,
    output logic                  done
);

    localparam logic [ADDR_W-1:0] ROW_OFS = ADDR_W'(IMG_W);
    localparam pix_idx_t          K_LAST  = pix_idx_t'(PIX_PER_SUB - 1);

    state_t                state;
    pix_idx_t              k;
    pix_idx_t              k_next;
    logic [SUB_DATA_W-1:0] sub_buf;
    logic [ADDR_W-1:0]     subX;
    logic [ADDR_W-1:0]     subY;
    logic [ADDR_W-1:0]     rowBase;
    logic [ADDR_W-1:0]     tile_base;
    logic [ADDR_W-1:0]     addr_next;
    logic                  last;
    logic                  advance;
    logic                  clear;

    assign advance = (state == ST_ACK);
    assign clear   = ((state == ST_IDLE || state == ST_DONE) && start)
                   || (state == ST_ACK && last);

    tile_position_counter #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) u_pos (
        .clock   (clock),
        .reset   (reset),
        .advance (advance),
        .clear   (clear),
        .subX    (subX),
        .subY    (subY),
        .rowBase (rowBase),
        .last    (last)
    );

    // Outputs are registered, so the address/data for pixel k+1 are prepared while k is shown.
    always_comb begin
        k_next    = k + 2'd1;
        tile_base = rowBase + subX;
        addr_next = tile_base + (k_next[1] ? ROW_OFS : '0) + ADDR_W'(k_next[0]);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            k          <= '0;
            sub_buf    <= '0;
            processed  <= 1'b0;
            memWriteEn <= 1'b0;
            memAddress <= '0;
            memData    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            processed  <= 1'b0;
            memWriteEn <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        done  <= 1'b0;
                        busy  <= 1'b1;
                        state <= ST_WAIT_SUB;
                    end
                end
                ST_WAIT_SUB: begin
                    if (readyToBeProcessed) begin
                        sub_buf    <= imageGeneratorInput;
                        k          <= '0;
                        memWriteEn <= 1'b1;
                        memAddress <= tile_base;
                        memData    <= sub_pixel(imageGeneratorInput, 2'd0);
                        state      <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (k == K_LAST) begin
                        processed <= 1'b1;
                        state     <= ST_ACK;
                    end else begin
                        k          <= k_next;
                        memWriteEn <= 1'b1;
                        memAddress <= addr_next;
                        memData    <= sub_pixel(sub_buf, k_next);
                    end
                end
                ST_ACK: begin
                    if (last) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        state <= ST_WAIT_SUB;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_encrypted_image_writer.sv
// Randomized self-checking bench for encrypted_image_writer on a 4x4 image (four tiles),
// with expected writes derived from tile index arithmetic in a reference model.
module tb_encrypted_image_writer;

    localparam int IMG_W  = 4;
    localparam int IMG_H  = 4;
    localparam int ADDR_W = 4;
    localparam int TILES  = (IMG_W / 2) * (IMG_H / 2);

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              readyToBeProcessed = 1'b0;
    logic [15:0]       imageGeneratorInput = '0;
    logic              processed;
    logic              memWriteEn;
    logic [ADDR_W-1:0] memAddress;
    logic [3:0]        memData;
    logic              busy;
    logic              done;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    encrypted_image_writer #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .start               (start),
        .readyToBeProcessed  (readyToBeProcessed),
        .imageGeneratorInput (imageGeneratorInput),
        .processed           (processed),
        .memWriteEn          (memWriteEn),
        .memAddress          (memAddress),
        .memData             (memData),
        .busy                (busy),
        .done                (done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: pixel k of tile t sits at (tx + k%2, ty + k/2) in the image.
    function automatic int model_addr(input int t, input int k);
        int tx = (t % (IMG_W / 2)) * 2;
        int ty = (t / (IMG_W / 2)) * 2;
        return (ty + k / 2) * IMG_W + tx + k % 2;
    endfunction

    function automatic int model_pix(input logic [15:0] d, input int k);
        return int'((d >> (12 - 4 * k)) & 16'hF);
    endfunction

    task automatic check_quiet(input string tag);
        check({tag, ".proc"}, 32'(processed), 0);
        check({tag, ".wen"},  32'(memWriteEn), 0);
        check({tag, ".addr"}, 32'(memAddress), 0);
        check({tag, ".data"}, 32'(memData), 0);
        check({tag, ".busy"}, 32'(busy), 0);
        check({tag, ".done"}, 32'(done), 0);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("start.busy", 32'(busy), 1);
        check("start.done", 32'(done), 0);
    endtask

    // Entered and left at a negedge where the DUT sits in WAIT_SUB (or DONE on exit).
    task automatic do_tile(input int t, input logic [15:0] d, input int stall, input bit pulse_start);
        readyToBeProcessed = 1'b0;
        for (int i = 0; i < stall; i++) begin
            check("stall.wen",  32'(memWriteEn), 0);
            check("stall.proc", 32'(processed), 0);
            check("stall.busy", 32'(busy), 1);
            @(negedge clock);
        end
        readyToBeProcessed  = 1'b1;
        imageGeneratorInput = d;
        @(negedge clock);
        for (int k = 0; k < 4; k++) begin
            imageGeneratorInput = 16'($urandom);
            check("wr.wen",  32'(memWriteEn), 1);
            check("wr.addr", 32'(memAddress), 32'(model_addr(t, k)));
            check("wr.data", 32'(memData), 32'(model_pix(d, k)));
            check("wr.proc", 32'(processed), 0);
            if (pulse_start && k == 1) start = 1'b1;
            if (k == 2) start = 1'b0;
            @(negedge clock);
        end
        check("ack.proc", 32'(processed), 1);
        check("ack.wen",  32'(memWriteEn), 0);
        readyToBeProcessed = 1'b0;
        start = 1'b0;
        @(negedge clock);
        check("post.proc", 32'(processed), 0);
        check("post.busy", 32'(busy), (t == TILES - 1) ? 0 : 1);
        check("post.done", 32'(done), (t == TILES - 1) ? 1 : 0);
    endtask

    initial begin
        logic [15:0] d;

        repeat (2) @(negedge clock);
        check_quiet("rst");
        reset = 1'b0;
        @(negedge clock);
        check_quiet("idle");

        // First image: directed tiles, backpressure, start during WRITE.
        do_start();
        do_tile(0, 16'hABCD, 0, 1'b0);
        do_tile(1, 16'h1234, 0, 1'b1);
        do_tile(2, 16'($urandom), 10, 1'b0);
        do_tile(3, 16'($urandom), $urandom_range(0, 3), 1'b0);
        repeat (3) begin
            @(negedge clock);
            check("done.hold", 32'(done), 1);
            check("done.busy", 32'(busy), 0);
            check("done.wen",  32'(memWriteEn), 0);
        end

        // Restart from DONE: first tile back at address 0.
        do_start();
        do_tile(0, 16'h5A3C, 1, 1'b0);

        // Reset after the 2nd WRITE cycle of tile 1.
        d = 16'($urandom);
        readyToBeProcessed  = 1'b1;
        imageGeneratorInput = d;
        @(negedge clock);
        for (int k = 0; k < 2; k++) begin
            check("part.addr", 32'(memAddress), 32'(model_addr(1, k)));
            check("part.data", 32'(memData), 32'(model_pix(d, k)));
            if (k == 1) reset = 1'b1;
            @(negedge clock);
        end
        readyToBeProcessed = 1'b0;
        check_quiet("midrst1");
        @(negedge clock);
        check_quiet("midrst2");
        reset = 1'b0;
        repeat (4) begin
            @(negedge clock);
            check("rstidle.proc", 32'(processed), 0);
            check("rstidle.wen",  32'(memWriteEn), 0);
        end

        // Full randomized image after reset.
        do_start();
        for (int t = 0; t < TILES; t++)
            do_tile(t, 16'($urandom), int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
        @(negedge clock);
        check("final.done", 32'(done), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
